boot_seq_ctrl: RTL and testbench
================================

BOOT_SEQ_CTRL -- requirements
Module: boot_seq_ctrl

Interface
REQ-001 SHALL have parameters: DIV_HALF, 10, half-period of divided clock in clkyuanshi cycles (2..255).
REQ-002 SHALL have parameters: RST_STRETCH, 11, clkyuanshi cycles system reset is held after rstyuanshi release (1..255).
REQ-003 SHALL have parameters: IDLE_TO, 50000, rx-idle cycles that end a download (1..2^20-1).
REQ-004 SHALL have parameters: MAX_BYTES, 16384, byte limit per download (4..65535, multiple of 4).
REQ-005 clkyuanshi  in  1  system clock; reset rstyuanshi, asynchronous, active-low; clock clkyuanshi.
REQ-006 rstyuanshi  in  1  asynchronous active-low reset.
REQ-007 debug_pin_i  in  1  download target: 1 ROM, 0 RAM; synchronous, sampled on entry to LOAD.
REQ-008 rx_done_i  in  1  one-cycle pulse per received UART byte, synchronous to clkyuanshi.
REQ-009 dl_req_i  in  1  re-download request, level, synchronous.
REQ-010 skip_i  in  1  leave LOAD with zero bytes received.
REQ-011 clk_div_o  out  1  square wave, period 2*DIV_HALF.
REQ-012 clk_en_o  out  1  one-cycle pulse coincident with each clk_div_o rising toggle.
REQ-013 sys_rst_n_o  out  1  stretched synchronous system reset.
REQ-014 cpu_rst_n_o  out  1  CPU reset, low outside RUN.
REQ-015 rom_wr_en_o / ram_wr_en_o  out  1 each  download-path enables, mutually exclusive.
REQ-016 byte_cnt_o  out  16  bytes received in current/last download.
REQ-017 state_o  out  2  RST=0, LOAD=1, RUN=2, DRAIN=3.
REQ-018 err_o  out  1  sticky: last download ended with byte_cnt not multiple of 4 or hit MAX_BYTES.

Function
REQ-019 Divider counter SHALL count 0..DIV_HALF-1 continuously, independent of FSM; clk_div_o SHALL toggle when count==DIV_HALF-1; clk_en_o SHALL pulse on that cycle only when clk_div_o is 0 before toggling.
REQ-020 RST: sys_rst_n_o=0, stretch counter increments; after RST_STRETCH cycles SHALL set sys_rst_n_o=1 and go to LOAD.
REQ-021 LOAD entry: latch debug_pin_i; clear byte_cnt_o, idle counter, err_o; assert rom_wr_en_o if latched 1 else ram_wr_en_o.
REQ-022 LOAD: each rx_done_i SHALL increment byte_cnt_o and clear idle counter; otherwise idle counter increments, saturating.
REQ-023 LOAD -> RUN when byte_cnt_o>0 and idle counter reaches IDLE_TO, or when byte_cnt_o reaches MAX_BYTES (err_o=1), or when skip_i=1 with byte_cnt_o==0.
REQ-024 LOAD with byte_cnt_o==0 and skip_i=0 SHALL wait indefinitely (no timeout).
REQ-025 On exit from LOAD, err_o SHALL be set if byte_cnt_o[1:0]!=0; both wr_en outputs SHALL deassert in the same cycle cpu_rst_n_o rises.
REQ-026 RUN: cpu_rst_n_o=1; rx_done_i ignored; dl_req_i rising edge SHALL go to DRAIN.
REQ-027 DRAIN: cpu_rst_n_o=0 immediately; wait 2*DIV_HALF*4 cycles, then LOAD.
REQ-028 rx_done_i coincident with the transition cycle out of LOAD SHALL be counted but SHALL NOT delay the transition; byte_cnt_o SHALL NOT wrap.
REQ-029 All FSM outputs are registered; latency from condition to output is one cycle.

Reset
REQ-030 rstyuanshi low at any time, including mid-LOAD, SHALL asynchronously force: state RST, divider 0, clk_div_o=0, clk_en_o=0, sys_rst_n_o=0, cpu_rst_n_o=0, both wr_en=0, byte_cnt_o=0, err_o=0, counters 0.

Structure
REQ-031 State encodings and parameter defaults SHALL live in the shared defines package.
REQ-032 Divider SHALL be one sub-module, clk_div_gen (clk_div_o, clk_en_o); FSM and counters in boot_seq_ctrl.

Verification
REQ-033 Reset release, DIV_HALF=10: clk_div_o period 20, clk_en_o every 20 cycles; sys_rst_n_o rises 11 cycles after release.
REQ-034 debug_pin_i=1, 8 rx pulses then idle IDLE_TO=100: rom_wr_en_o=1 during load, RUN after 100 idle cycles, byte_cnt_o=8, err_o=0.
REQ-035 debug_pin_i=0, 6 bytes then idle: RUN, ram_wr_en_o used, err_o=1.
REQ-036 MAX_BYTES=16, 20 pulses back-to-back: RUN at byte 16, byte_cnt_o=16, err_o=1.
REQ-037 RUN, dl_req_i rises: cpu_rst_n_o=0 next cycle, LOAD after 80 cycles, byte_cnt_o=0.
REQ-038 rstyuanshi low mid-LOAD after 3 bytes: all outputs reset values immediately, RST sequence restarts.

Source files
------------

// File: rtl/boot_seq_ctrl_pkg.sv
// Shared definitions for the boot sequencer: FSM state encoding, parameter
// defaults, counter widths and the drain-length helper.
package boot_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int DEF_DIV_HALF    = 10;
    localparam int DEF_RST_STRETCH = 11;
    localparam int DEF_IDLE_TO     = 50000;
    localparam int DEF_MAX_BYTES   = 16384;

    localparam int STRETCH_W = 8;
    localparam int IDLE_W    = 20;
    localparam int BYTE_W    = 16;
    localparam int DRAIN_W   = 11;

    // DRAIN lasts four full periods of the divided clock.
    function automatic int drain_len(int div_half);
        return 8 * div_half;
    endfunction

endpackage

// File: rtl/boot_seq_ctrl_if.sv
// Bundle of the boot sequencer's control inputs and status outputs.
//   debug_pin_i, rx_done_i, dl_req_i, skip_i : requests into the sequencer
//   clk_div_o, clk_en_o                     : divided clock and its enable
//   sys_rst_n_o, cpu_rst_n_o                 : system / CPU resets
//   rom_wr_en_o, ram_wr_en_o                 : download path enables
//   byte_cnt_o, state_o, err_o               : download status
// slave is the sequencer side, master the side that drives the requests.
interface boot_seq_ctrl_if;
    import boot_seq_ctrl_pkg::*;

    logic              debug_pin_i;
    logic              rx_done_i;
    logic              dl_req_i;
    logic              skip_i;
    logic              clk_div_o;
    logic              clk_en_o;
    logic              sys_rst_n_o;
    logic              cpu_rst_n_o;
    logic              rom_wr_en_o;
    logic              ram_wr_en_o;
    logic [BYTE_W-1:0] byte_cnt_o;
    logic [1:0]        state_o;
    logic              err_o;

    modport slave (
        input  debug_pin_i, rx_done_i, dl_req_i, skip_i,
        output clk_div_o, clk_en_o, sys_rst_n_o, cpu_rst_n_o,
               rom_wr_en_o, ram_wr_en_o, byte_cnt_o, state_o, err_o
    );

    modport master (
        output debug_pin_i, rx_done_i, dl_req_i, skip_i,
        input  clk_div_o, clk_en_o, sys_rst_n_o, cpu_rst_n_o,
               rom_wr_en_o, ram_wr_en_o, byte_cnt_o, state_o, err_o
    );

endinterface

// File: rtl/boot_seq_ctrl_clk_div_gen.sv
// Free-running clock divider. Produces a square wave of period 2*DIV_HALF
// and a one-cycle enable that is high in the same cycle clk_div_o rises.
//   clkyuanshi  : system clock
//   rstyuanshi  : asynchronous active-low reset
//   clk_div_o   : divided clock
//   clk_en_o    : rising-toggle enable pulse
module clk_div_gen
    import boot_seq_ctrl_pkg::*;
#(
    parameter int DIV_HALF = DEF_DIV_HALF
) (
    input  logic clkyuanshi,
    input  logic rstyuanshi,
    output logic clk_div_o,
    output logic clk_en_o
);

    localparam logic [7:0] CNT_LAST = 8'(DIV_HALF - 1);

    logic [7:0] cnt;

    always_ff @(posedge clkyuanshi or negedge rstyuanshi) begin
        if (!rstyuanshi) begin
            cnt       <= 8'd0;
            clk_div_o <= 1'b0;
            clk_en_o  <= 1'b0;
        end else begin
            clk_en_o <= 1'b0;
            if (cnt == CNT_LAST) begin
                cnt       <= 8'd0;
                clk_div_o <= ~clk_div_o;
                // Registered alongside the toggle so it lines up with the rise.
                clk_en_o  <= ~clk_div_o;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: stretches the system reset, supervises a UART download
// into ROM or RAM, releases the CPU, and re-enters the download on request.
//   clkyuanshi : system clock
//   rstyuanshi : asynchronous active-low reset
//   bus        : boot_seq_ctrl_if.slave (requests in, status/enables out)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RST   | system reset held low for RST_STRETCH cycles
//   ST_LOAD  | download in progress, byte counting, idle timeout
//   ST_RUN   | CPU released, waiting for a re-download request
//   ST_DRAIN | CPU held in reset for four divided-clock periods
module boot_seq_ctrl
    import boot_seq_ctrl_pkg::*;
#(
    parameter int DIV_HALF    = DEF_DIV_HALF,
    parameter int RST_STRETCH = DEF_RST_STRETCH,
    parameter int IDLE_TO     = DEF_IDLE_TO,
    parameter int MAX_BYTES   = DEF_MAX_BYTES
) (
    input  logic            clkyuanshi,
    input  logic            rstyuanshi,
    boot_seq_ctrl_if.slave  bus
);

    localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(RST_STRETCH - 1);
    localparam logic [IDLE_W-1:0]    IDLE_LIMIT   = IDLE_W'(IDLE_TO);
    localparam logic [BYTE_W-1:0]    MAX_CNT      = BYTE_W'(MAX_BYTES);
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST   = DRAIN_W'(drain_len(DIV_HALF) - 1);

    logic clk_div;
    logic clk_en;

    clk_div_gen #(
        .DIV_HALF (DIV_HALF)
    ) u_clk_div_gen (
        .clkyuanshi (clkyuanshi),
        .rstyuanshi (rstyuanshi),
        .clk_div_o  (clk_div),
        .clk_en_o   (clk_en)
    );

    state_t               state;
    logic [STRETCH_W-1:0] stretch_cnt;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [BYTE_W-1:0]    byte_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 dl_req_q;
    logic                 sys_rst_n;
    logic                 cpu_rst_n;
    logic                 rom_wr_en;
    logic                 ram_wr_en;
    logic                 err;

    logic [BYTE_W-1:0]    byte_cnt_nxt;
    logic                 max_hit;
    logic                 load_exit;
    logic                 enter_load;

    always_comb begin
        byte_cnt_nxt = byte_cnt;
        // Saturating at the limit keeps the count from ever wrapping.
        if (bus.rx_done_i && (byte_cnt != MAX_CNT)) begin
            byte_cnt_nxt = byte_cnt + 16'd1;
        end
        // The byte that reaches the limit ends the download in the same cycle.
        max_hit = (byte_cnt_nxt == MAX_CNT);
        // Idle and skip exits look only at registered values, so a byte
        // arriving in the exit cycle is counted without postponing the exit.
        load_exit = ((byte_cnt != '0) && (idle_cnt == IDLE_LIMIT)) ||
                    max_hit ||
                    (bus.skip_i && (byte_cnt == '0));
        enter_load = ((state == ST_RST)   && (stretch_cnt == STRETCH_LAST)) ||
                     ((state == ST_DRAIN) && (drain_cnt == '0));
    end

    always_ff @(posedge clkyuanshi or negedge rstyuanshi) begin
        if (!rstyuanshi) begin
            state       <= ST_RST;
            stretch_cnt <= '0;
            idle_cnt    <= '0;
            byte_cnt    <= '0;
            drain_cnt   <= '0;
            dl_req_q    <= 1'b0;
            sys_rst_n   <= 1'b0;
            cpu_rst_n   <= 1'b0;
            rom_wr_en   <= 1'b0;
            ram_wr_en   <= 1'b0;
            err         <= 1'b0;
        end else begin
            dl_req_q <= bus.dl_req_i;
            case (state)
                ST_RST: begin
                    if (stretch_cnt == STRETCH_LAST) begin
                        sys_rst_n <= 1'b1;
                    end else begin
                        stretch_cnt <= stretch_cnt + 8'd1;
                    end
                end
                ST_LOAD: begin
                    byte_cnt <= byte_cnt_nxt;
                    if (bus.rx_done_i) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + 20'd1;
                    end
                    if (load_exit) begin
                        state     <= ST_RUN;
                        cpu_rst_n <= 1'b1;
                        rom_wr_en <= 1'b0;
                        ram_wr_en <= 1'b0;
                        err       <= (byte_cnt_nxt[1:0] != 2'b00) || max_hit;
                    end
                end
                ST_RUN: begin
                    if (bus.dl_req_i && !dl_req_q) begin
                        state     <= ST_DRAIN;
                        cpu_rst_n <= 1'b0;
                        drain_cnt <= DRAIN_LAST;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 11'd1;
                    end
                end
                default: state <= ST_RST;
            endcase

            // Shared entry into LOAD from both RST and DRAIN.
            if (enter_load) begin
                state     <= ST_LOAD;
                byte_cnt  <= '0;
                idle_cnt  <= '0;
                err       <= 1'b0;
                rom_wr_en <= bus.debug_pin_i;
                ram_wr_en <= ~bus.debug_pin_i;
            end
        end
    end

    assign bus.clk_div_o   = clk_div;
    assign bus.clk_en_o    = clk_en;
    assign bus.sys_rst_n_o = sys_rst_n;
    assign bus.cpu_rst_n_o = cpu_rst_n;
    assign bus.rom_wr_en_o = rom_wr_en;
    assign bus.ram_wr_en_o = ram_wr_en;
    assign bus.byte_cnt_o  = byte_cnt;
    assign bus.state_o     = state;
    assign bus.err_o       = err;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed bench for boot_seq_ctrl with DIV_HALF=10, RST_STRETCH=11,
// IDLE_TO=100, MAX_BYTES=16.
module tb_boot_seq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    boot_seq_ctrl_if bus ();

    boot_seq_ctrl #(
        .DIV_HALF    (10),
        .RST_STRETCH (11),
        .IDLE_TO     (100),
        .MAX_BYTES   (16)
    ) dut (
        .clkyuanshi (clk),
        .rstyuanshi (rst_n),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        bus.rx_done_i = 1'b1;
        tick();
        bus.rx_done_i = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (bus.state_o != 2'd2 && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_sys_rst(output int n);
        n = 0;
        while (bus.sys_rst_n_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    // From RUN: request a re-download and wait until LOAD is reached.
    task automatic go_load(input logic dbg);
        int n;
        bus.debug_pin_i = dbg;
        bus.dl_req_i    = 1'b1;
        tick();
        bus.dl_req_i    = 1'b0;
        n = 0;
        while (bus.state_o != 2'd1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        logic [24:0] outs;
        rst_n           = 1'b0;
        bus.debug_pin_i = 1'b1;
        bus.rx_done_i   = 1'b0;
        bus.dl_req_i    = 1'b0;
        bus.skip_i      = 1'b0;
        tick();
        tick();
        outs = {bus.clk_div_o, bus.clk_en_o, bus.sys_rst_n_o, bus.cpu_rst_n_o,
                bus.rom_wr_en_o, bus.ram_wr_en_o, bus.err_o, bus.state_o, bus.byte_cnt_o};
        checks++;
        if (outs !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", outs, 25'd0);
        end
        rst_n = 1'b1;
        wait_sys_rst(n);
        checks++;
        if (n !== 11) begin
            errors++;
            $display("FAIL sys_rst_stretch: got %0d cycles expected %0d", n, 11);
        end
        checks++;
        if (bus.state_o !== 2'd1) begin
            errors++;
            $display("FAIL state_after_stretch: got %0d expected %0d", bus.state_o, 1);
        end
        checks++;
        if ({bus.rom_wr_en_o, bus.ram_wr_en_o, bus.cpu_rst_n_o} !== 3'b100) begin
            errors++;
            $display("FAIL load_enables_rom: got %b expected %b",
                     {bus.rom_wr_en_o, bus.ram_wr_en_o, bus.cpu_rst_n_o}, 3'b100);
        end
    endtask

    task automatic test_divider();
        int   e1, e2, en_cnt, hi_cnt, bad;
        logic prev_div;
        e1 = -1; e2 = -1; en_cnt = 0; hi_cnt = 0; bad = 0;
        prev_div = bus.clk_div_o;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.clk_en_o === 1'b1) begin
                en_cnt++;
                if (!(bus.clk_div_o === 1'b1 && prev_div === 1'b0)) bad++;
                if (e1 < 0) e1 = i;
                else if (e2 < 0) e2 = i;
            end
            if (e1 >= 0 && e2 < 0 && bus.clk_div_o === 1'b1) hi_cnt++;
            prev_div = bus.clk_div_o;
        end
        checks++;
        if (e2 - e1 !== 20) begin
            errors++;
            $display("FAIL clk_en_period: got %0d expected %0d", e2 - e1, 20);
        end
        checks++;
        if (hi_cnt !== 10) begin
            errors++;
            $display("FAIL clk_div_high_time: got %0d expected %0d", hi_cnt, 10);
        end
        checks++;
        if (en_cnt !== 5) begin
            errors++;
            $display("FAIL clk_en_count_100: got %0d expected %0d", en_cnt, 5);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL clk_en_on_rise: got %0d misplaced expected %0d", bad, 0);
        end
        // 100 cycles with no bytes is already at the idle limit: must still wait.
        checks++;
        if (bus.state_o !== 2'd1) begin
            errors++;
            $display("FAIL no_timeout_empty: got state %0d expected %0d", bus.state_o, 1);
        end
    endtask

    task automatic test_rom_load();
        int n;
        for (int i = 0; i < 8; i++) begin
            tick();
            tick();
            pulse();
        end
        checks++;
        if (bus.byte_cnt_o !== 16'd8 || bus.rom_wr_en_o !== 1'b1) begin
            errors++;
            $display("FAIL rom_load_progress: got cnt %0d rom %b expected 8 1",
                     bus.byte_cnt_o, bus.rom_wr_en_o);
        end
        wait_run(n);
        checks++;
        if (n !== 101) begin
            errors++;
            $display("FAIL rom_idle_exit: got %0d cycles expected %0d", n, 101);
        end
        checks++;
        if ({bus.byte_cnt_o, bus.err_o, bus.cpu_rst_n_o, bus.rom_wr_en_o, bus.ram_wr_en_o}
            !== {16'd8, 4'b0100}) begin
            errors++;
            $display("FAIL rom_run_status: got cnt %0d err %b cpu %b rom %b ram %b expected 8 0 1 0 0",
                     bus.byte_cnt_o, bus.err_o, bus.cpu_rst_n_o, bus.rom_wr_en_o, bus.ram_wr_en_o);
        end
    endtask

    task automatic test_drain();
        int n;
        bus.debug_pin_i = 1'b0;
        bus.dl_req_i    = 1'b1;
        tick();
        bus.dl_req_i    = 1'b0;
        checks++;
        if (bus.state_o !== 2'd3 || bus.cpu_rst_n_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_entry: got state %0d cpu %b expected 3 0",
                     bus.state_o, bus.cpu_rst_n_o);
        end
        n = 0;
        while (bus.state_o != 2'd1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 80) begin
            errors++;
            $display("FAIL drain_length: got %0d cycles expected %0d", n, 80);
        end
        checks++;
        if ({bus.byte_cnt_o, bus.err_o, bus.rom_wr_en_o, bus.ram_wr_en_o} !== {16'd0, 3'b001}) begin
            errors++;
            $display("FAIL drain_reload: got cnt %0d err %b rom %b ram %b expected 0 0 0 1",
                     bus.byte_cnt_o, bus.err_o, bus.rom_wr_en_o, bus.ram_wr_en_o);
        end
    endtask

    task automatic test_ram_err();
        int n;
        repeat (300) tick();
        checks++;
        if (bus.state_o !== 2'd1) begin
            errors++;
            $display("FAIL ram_wait_empty: got state %0d expected %0d", bus.state_o, 1);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            pulse();
        end
        wait_run(n);
        checks++;
        if (n !== 101) begin
            errors++;
            $display("FAIL ram_idle_exit: got %0d cycles expected %0d", n, 101);
        end
        checks++;
        if ({bus.byte_cnt_o, bus.err_o, bus.cpu_rst_n_o, bus.ram_wr_en_o} !== {16'd6, 3'b110}) begin
            errors++;
            $display("FAIL ram_run_status: got cnt %0d err %b cpu %b ram %b expected 6 1 1 0",
                     bus.byte_cnt_o, bus.err_o, bus.cpu_rst_n_o, bus.ram_wr_en_o);
        end
    endtask

    task automatic test_max_bytes();
        int run_at;
        go_load(1'b0);
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared_on_load: got %b expected %b", bus.err_o, 1'b0);
        end
        run_at = 0;
        bus.rx_done_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.state_o == 2'd2 && run_at == 0) run_at = i;
        end
        bus.rx_done_i = 1'b0;
        checks++;
        if (run_at !== 16) begin
            errors++;
            $display("FAIL max_exit_byte: got %0d expected %0d", run_at, 16);
        end
        checks++;
        if ({bus.byte_cnt_o, bus.err_o, bus.state_o} !== {16'd16, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL max_status: got cnt %0d err %b state %0d expected 16 1 2",
                     bus.byte_cnt_o, bus.err_o, bus.state_o);
        end
    endtask

    task automatic test_skip();
        go_load(1'b1);
        bus.skip_i = 1'b1;
        tick();
        bus.skip_i = 1'b0;
        checks++;
        if ({bus.state_o, bus.byte_cnt_o, bus.err_o, bus.rom_wr_en_o} !== {2'd2, 16'd0, 2'b00}) begin
            errors++;
            $display("FAIL skip_exit: got state %0d cnt %0d err %b rom %b expected 2 0 0 0",
                     bus.state_o, bus.byte_cnt_o, bus.err_o, bus.rom_wr_en_o);
        end
        // A byte landing in the exit cycle is counted and the exit still happens.
        go_load(1'b0);
        bus.skip_i    = 1'b1;
        bus.rx_done_i = 1'b1;
        tick();
        bus.skip_i    = 1'b0;
        bus.rx_done_i = 1'b0;
        checks++;
        if ({bus.state_o, bus.byte_cnt_o, bus.err_o} !== {2'd2, 16'd1, 1'b1}) begin
            errors++;
            $display("FAIL skip_with_byte: got state %0d cnt %0d err %b expected 2 1 1",
                     bus.state_o, bus.byte_cnt_o, bus.err_o);
        end
    endtask

    task automatic test_reset_mid_load();
        int n;
        logic [24:0] outs;
        go_load(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            pulse();
        end
        checks++;
        if (bus.byte_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL mid_load_count: got %0d expected %0d", bus.byte_cnt_o, 3);
        end
        #3;
        rst_n = 1'b0;
        #1;
        outs = {bus.clk_div_o, bus.clk_en_o, bus.sys_rst_n_o, bus.cpu_rst_n_o,
                bus.rom_wr_en_o, bus.ram_wr_en_o, bus.err_o, bus.state_o, bus.byte_cnt_o};
        checks++;
        if (outs !== 25'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h expected %h", outs, 25'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        wait_sys_rst(n);
        checks++;
        if (n !== 11 || bus.state_o !== 2'd1 || bus.byte_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL restart_sequence: got %0d cycles state %0d cnt %0d expected 11 1 0",
                     n, bus.state_o, bus.byte_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_rom_load();
        test_drain();
        test_ram_err();
        test_max_bytes();
        test_skip();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
